// File: rtl/regfile_op_sequencer.sv
// Multi-cycle sequencer owning both read and both write ports of a 2**AW x DW register file.
// Optional build macro RF_CLEAR_ON_RESET_EN: clear every register two-at-a-time after reset.
module regfile_op_sequencer #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic [2:0]    CMD_OP,
  input  logic [AW-1:0] CMD_RD,
  input  logic [AW-1:0] CMD_RS,
  input  logic [AW-1:0] CMD_RT,
  input  logic [DW-1:0] CMD_IMM,
  output logic          DONE,
  output logic [DW-1:0] RESULT,
  output logic          FLAG_Z,
  output logic          FLAG_C,
  output logic          BUSY,
  output logic [AW-1:0] WAA,
  output logic [DW-1:0] WDA,
  output logic          WEA,
  output logic [AW-1:0] WAB,
  output logic [DW-1:0] WDB,
  output logic          WEB,
  output logic [AW-1:0] RAA,
  input  logic [DW-1:0] RDA,
  output logic          REA,
  output logic [AW-1:0] RAB,
  input  logic [DW-1:0] RDB,
  output logic          REB
);

  localparam logic [2:0] OP_NOP = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4, OP_LDI = 3'd5, OP_MOV = 3'd6, OP_SWAP = 3'd7;

  typedef enum logic [1:0] {INIT, IDLE, READ, WRITE} state_t;

  state_t        state;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q, rs_q, rt_q;
`ifdef RF_CLEAR_ON_RESET_EN
  localparam logic [AW-1:0] HALF = {1'b1, {(AW-1){1'b0}}};
  logic [AW-1:0] clr_cnt;
`endif

  logic          idle_direct, do_wb;
  logic [2:0]    op_s;
  logic [AW-1:0] rd_s, rs_s, rt_s;
  logic [DW:0]   sum, diff;
  logic          wb_wea, wb_web, wb_setf, wb_z, wb_c;
  logic [AW-1:0] wb_waa, wb_wab;
  logic [DW-1:0] wb_wda, wb_wdb, wb_res;

  assign CMD_READY   = (state == IDLE);
  assign BUSY        = (state != IDLE);
  assign idle_direct = CMD_VALID && (CMD_OP == OP_NOP || CMD_OP == OP_LDI);
  assign do_wb       = (state == READ) || (state == IDLE && idle_direct);

  // NOP/LDI skip READ, so their write-back is decoded straight from the command inputs.
  assign op_s = (state == IDLE) ? CMD_OP : op_q;
  assign rd_s = (state == IDLE) ? CMD_RD : rd_q;
  assign rs_s = (state == IDLE) ? CMD_RS : rs_q;
  assign rt_s = (state == IDLE) ? CMD_RT : rt_q;
  assign sum  = {1'b0, RDA} + {1'b0, RDB};
  assign diff = {1'b0, RDA} - {1'b0, RDB};

  always_comb begin
    wb_wea  = 1'b0;
    wb_web  = 1'b0;
    wb_waa  = rd_s;
    wb_wab  = rt_s;
    wb_wda  = '0;
    wb_wdb  = RDA;
    wb_res  = RESULT;
    wb_setf = 1'b0;
    wb_z    = 1'b0;
    wb_c    = 1'b0;
    case (op_s)
      OP_ADD: begin wb_wea = 1'b1; wb_wda = sum[DW-1:0];  wb_setf = 1'b1; wb_c = sum[DW];  end
      OP_SUB: begin wb_wea = 1'b1; wb_wda = diff[DW-1:0]; wb_setf = 1'b1; wb_c = diff[DW]; end
      OP_AND: begin wb_wea = 1'b1; wb_wda = RDA & RDB;    wb_setf = 1'b1; end
      OP_OR:  begin wb_wea = 1'b1; wb_wda = RDA | RDB;    wb_setf = 1'b1; end
      OP_LDI: begin wb_wea = 1'b1; wb_wda = CMD_IMM; end
      OP_MOV: begin wb_wea = 1'b1; wb_wda = RDA; end
      OP_SWAP: begin
        wb_wea = 1'b1;
        wb_waa = rs_s;
        wb_wda = RDB;
        wb_web = (rs_s != rt_s);
      end
      default: ;
    endcase
    if (wb_wea) wb_res = wb_wda;
    wb_z = (wb_wda == '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
`ifdef RF_CLEAR_ON_RESET_EN
      state   <= INIT;
      clr_cnt <= '0;
`else
      state   <= IDLE;
`endif
      op_q <= '0;  rd_q <= '0;  rs_q <= '0;  rt_q <= '0;
      DONE <= 1'b0; RESULT <= '0; FLAG_Z <= 1'b0; FLAG_C <= 1'b0;
      WAA <= '0; WDA <= '0; WEA <= 1'b0;
      WAB <= '0; WDB <= '0; WEB <= 1'b0;
      RAA <= '0; REA <= 1'b0; RAB <= '0; REB <= 1'b0;
    end else begin
      case (state)
`ifdef RF_CLEAR_ON_RESET_EN
        INIT: begin
          if (clr_cnt == HALF) begin
            WEA   <= 1'b0;
            WEB   <= 1'b0;
            state <= IDLE;
          end else begin
            WEA     <= 1'b1;
            WEB     <= 1'b1;
            WAA     <= {clr_cnt[AW-2:0], 1'b0};
            WAB     <= {clr_cnt[AW-2:0], 1'b1};
            WDA     <= '0;
            WDB     <= '0;
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
`endif
        IDLE: begin
          if (CMD_VALID) begin
            op_q <= CMD_OP;
            rd_q <= CMD_RD;
            rs_q <= CMD_RS;
            rt_q <= CMD_RT;
            if (idle_direct) begin
              state <= WRITE;
            end else begin
              state <= READ;
              RAA   <= CMD_RS;
              RAB   <= CMD_RT;
              REA   <= 1'b1;
              REB   <= 1'b1;
            end
          end
        end
        READ: begin
          REA   <= 1'b0;
          REB   <= 1'b0;
          state <= WRITE;
        end
        WRITE: begin
          DONE  <= 1'b0;
          WEA   <= 1'b0;
          WEB   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (do_wb) begin
        DONE   <= 1'b1;
        WEA    <= wb_wea;
        WEB    <= wb_web;
        WAA    <= wb_waa;
        WDA    <= wb_wda;
        WAB    <= wb_wab;
        WDB    <= wb_wdb;
        RESULT <= wb_res;
        if (wb_setf) begin
          FLAG_Z <= wb_z;
          FLAG_C <= wb_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: directed commands against a behavioural register file, scoreboarded on DONE.
module tb_regfile_op_sequencer;
  localparam int DW = 16, AW = 4, NV = 18;

  logic          CLK = 1'b0, RST = 1'b1;
  logic          CMD_VALID = 1'b0, CMD_READY;
  logic [2:0]    CMD_OP = '0;
  logic [AW-1:0] CMD_RD = '0, CMD_RS = '0, CMD_RT = '0;
  logic [DW-1:0] CMD_IMM = '0;
  logic          DONE, FLAG_Z, FLAG_C, BUSY, WEA, WEB, REA, REB;
  logic [DW-1:0] RESULT, WDA, WDB, RDA, RDB;
  logic [AW-1:0] WAA, WAB, RAA, RAB;

  regfile_op_sequencer #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_RD(CMD_RD), .CMD_RS(CMD_RS), .CMD_RT(CMD_RT), .CMD_IMM(CMD_IMM),
    .DONE(DONE), .RESULT(RESULT), .FLAG_Z(FLAG_Z), .FLAG_C(FLAG_C), .BUSY(BUSY),
    .WAA(WAA), .WDA(WDA), .WEA(WEA), .WAB(WAB), .WDB(WDB), .WEB(WEB),
    .RAA(RAA), .RDA(RDA), .REA(REA), .RAB(RAB), .RDB(RDB), .REB(REB)
  );

  always #5 CLK = ~CLK;

`ifdef RF_CLEAR_ON_RESET_EN
  localparam logic [DW-1:0] RF_POWERUP = 16'hDEAD;
  localparam logic [DW-1:0] R14_EXP    = 16'h0000;
`else
  localparam logic [DW-1:0] RF_POWERUP = 16'h0000;
  localparam logic [DW-1:0] R14_EXP    = 16'h5A5A;
`endif

  // Behavioural register file with asynchronous read.
  logic [DW-1:0] rf [16];
  logic          rf_init = 1'b1;
  assign RDA = rf[RAA];
  assign RDB = rf[RAB];
  always @(posedge CLK) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) rf[i] <= RF_POWERUP;
    end else begin
      if (WEA) rf[WAA] <= WDA;
      if (WEB) rf[WAB] <= WDB;
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] rd, rs, rt;
    logic [DW-1:0] imm, res;
    logic          z, c, wea, web;
    logic [AW-1:0] waa, wab;
    logic [DW-1:0] wdb;
  } vec_t;

  typedef struct {
    vec_t v;
    int   cyc;
    int   idx;
  } exp_t;

  vec_t vt [NV];
  exp_t sb [$];
  int   checks = 0, failures = 0, done_cnt = 0, we_viol = 0, rdy_viol = 0;

  function automatic vec_t mk(logic [2:0] op, logic [3:0] rd, logic [3:0] rs, logic [3:0] rt,
                              logic [15:0] imm, logic [15:0] res, logic z, logic c,
                              logic wea, logic web, logic [3:0] waa, logic [3:0] wab,
                              logic [15:0] wdb);
    vec_t v;
    v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.imm = imm; v.res = res;
    v.z = z; v.c = c; v.wea = wea; v.web = web; v.waa = waa; v.wab = wab; v.wdb = wdb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every DONE pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    logic init_pat;
`ifdef RF_CLEAR_ON_RESET_EN
    init_pat = (WDA == '0) && (WDB == '0) && !WAA[0] && WAB[0];
`else
    init_pat = 1'b0;
`endif
    if (!RST) begin
      if ((WEA || WEB) && !DONE && !init_pat) we_viol++;
      if (CMD_READY == BUSY) rdy_viol++;
      if (DONE) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("v%0d_cycle", e.idx), cyc, e.cyc);
          chk($sformatf("v%0d_wea_web", e.idx), {WEA, WEB}, {e.v.wea, e.v.web});
          chk($sformatf("v%0d_flags", e.idx), {FLAG_Z, FLAG_C}, {e.v.z, e.v.c});
          if (e.v.wea) begin
            chk($sformatf("v%0d_result", e.idx), RESULT, e.v.res);
            chk($sformatf("v%0d_porta", e.idx), {WAA, WDA}, {e.v.waa, e.v.res});
          end
          if (e.v.web) chk($sformatf("v%0d_portb", e.idx), {WAB, WDB}, {e.v.wab, e.v.wdb});
        end
      end
    end
  end

  task automatic send(input int i);
    int t;
    CMD_OP = vt[i].op; CMD_RD = vt[i].rd; CMD_RS = vt[i].rs; CMD_RT = vt[i].rt;
    CMD_IMM = vt[i].imm;
    CMD_VALID = 1'b1;
    t = 0;
    while (!CMD_READY && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (!CMD_READY) begin
      chk($sformatf("v%0d_accept_timeout", i), 32'd0, 32'd1);
    end else begin
      exp_t e;
      e.v = vt[i];
      e.idx = i;
      e.cyc = cyc + ((vt[i].op == 3'd0 || vt[i].op == 3'd5) ? 1 : 2);
      sb.push_back(e);
      @(negedge CLK);
    end
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while (done_cnt < n && t < 50) begin
      @(negedge CLK);
      t++;
    end
    chk("done_count", done_cnt, n);
  endtask

  function automatic logic [31:0] outs_packed();
    return {DONE, WEA, WEB, REA, REB, FLAG_Z, FLAG_C, |RESULT, |WAA, |WAB, |WDA, |WDB, |RAA, |RAB};
  endfunction

  initial begin
    //           op    rd  rs  rt  imm       res      z  c  wea web waa wab wdb
    vt[0]  = mk(3'd5, 1,  0,  0, 16'hFFFF, 16'hFFFF, 0, 0, 1, 0, 1,  0, 16'h0);
    vt[1]  = mk(3'd5, 2,  0,  0, 16'h0001, 16'h0001, 0, 0, 1, 0, 2,  0, 16'h0);
    vt[2]  = mk(3'd1, 3,  1,  2, 16'h0,    16'h0000, 1, 1, 1, 0, 3,  0, 16'h0);
    vt[3]  = mk(3'd5, 4,  0,  0, 16'h0005, 16'h0005, 1, 1, 1, 0, 4,  0, 16'h0);
    vt[4]  = mk(3'd5, 5,  0,  0, 16'h0007, 16'h0007, 1, 1, 1, 0, 5,  0, 16'h0);
    vt[5]  = mk(3'd2, 6,  4,  5, 16'h0,    16'hFFFE, 0, 1, 1, 0, 6,  0, 16'h0);
    vt[6]  = mk(3'd5, 7,  0,  0, 16'h1234, 16'h1234, 0, 1, 1, 0, 7,  0, 16'h0);
    vt[7]  = mk(3'd5, 8,  0,  0, 16'hABCD, 16'hABCD, 0, 1, 1, 0, 8,  0, 16'h0);
    vt[8]  = mk(3'd7, 0,  7,  8, 16'h0,    16'hABCD, 0, 1, 1, 1, 7,  8, 16'h1234);
    vt[9]  = mk(3'd7, 0,  7,  7, 16'h0,    16'hABCD, 0, 1, 1, 0, 7,  0, 16'h0);
    vt[10] = mk(3'd3, 9,  4,  5, 16'h0,    16'h0005, 0, 0, 1, 0, 9,  0, 16'h0);
    vt[11] = mk(3'd4, 10, 3,  3, 16'h0,    16'h0000, 1, 0, 1, 0, 10, 0, 16'h0);
    vt[12] = mk(3'd6, 11, 8,  0, 16'h0,    16'h1234, 1, 0, 1, 0, 11, 0, 16'h0);
    vt[13] = mk(3'd0, 0,  0,  0, 16'h0,    16'h0000, 1, 0, 0, 0, 0,  0, 16'h0);
    vt[14] = mk(3'd2, 2,  2,  1, 16'h0,    16'h0002, 0, 1, 1, 0, 2,  0, 16'h0);
    vt[15] = mk(3'd1, 13, 2,  2, 16'h0,    16'h0004, 0, 0, 1, 0, 13, 0, 16'h0);
    vt[16] = mk(3'd5, 14, 0,  0, 16'h5A5A, 16'h5A5A, 0, 0, 1, 0, 14, 0, 16'h0);
    vt[17] = mk(3'd6, 15, 14, 0, 16'h0,    R14_EXP,  0, 0, 1, 0, 15, 0, 16'h0);

    repeat (2) @(negedge CLK);
    rf_init = 1'b0;
    chk("reset_outputs", outs_packed(), 32'd0);
    RST = 1'b0;

`ifdef RF_CLEAR_ON_RESET_EN
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      chk($sformatf("init%0d", k), {CMD_READY, WEA, WEB, 4'(WAA), 4'(WAB), WDA, WDB},
          {1'b0, 1'b1, 1'b1, 4'(2 * k), 4'(2 * k + 1), 16'h0, 16'h0});
    end
    @(negedge CLK);
    chk("init_ready", CMD_READY, 1'b1);
    for (int r = 0; r < 16; r++) chk($sformatf("init_rf%0d", r), rf[r], 16'h0);
`endif

    // Back-to-back commands with CMD_VALID held high throughout.
    for (int i = 0; i < 16; i++) send(i);
    CMD_VALID = 1'b0;
    wait_done(16);
    chk("rf3",  rf[3],  16'h0000);
    chk("rf6",  rf[6],  16'hFFFE);
    chk("rf7",  rf[7],  16'hABCD);
    chk("rf8",  rf[8],  16'h1234);
    chk("rf9",  rf[9],  16'h0005);
    chk("rf2",  rf[2],  16'h0002);
    chk("rf13", rf[13], 16'h0004);

    send(16);
    CMD_VALID = 1'b0;
    wait_done(17);

    // ADD r14 = r1 + r2, aborted by reset during its READ cycle.
    CMD_OP = 3'd1; CMD_RD = 4'd14; CMD_RS = 4'd1; CMD_RT = 4'd2; CMD_VALID = 1'b1;
    @(negedge CLK);
    chk("abort_in_read", {BUSY, REA, REB}, 3'b111);
    CMD_VALID = 1'b0;
    RST = 1'b1;
    #1;
    chk("async_reset_outputs", outs_packed(), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
`ifndef RF_CLEAR_ON_RESET_EN
    chk("rf14_after_abort", rf[14], 16'h5A5A);
`endif
    send(17);
    CMD_VALID = 1'b0;
    wait_done(18);
    chk("rf14_final", rf[14], R14_EXP);
    chk("rf15_final", rf[15], R14_EXP);
    chk("scoreboard_empty", sb.size(), 0);
    chk("we_outside_write", we_viol, 0);
    chk("ready_vs_busy", rdy_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1);
  end

endmodule
